// File: rtl/rob_multi_commit_pkg.sv
// Shared ROB types: entry classes, default sizing, entry layout.
// Imported by rob_multi_commit and rob_commit_select.
package rob_multi_commit_pkg;

  localparam int DEPTH_DEF       = 16;
  localparam int IDX_W_DEF       = 4;
  localparam int FULL_MARGIN_DEF = 2;

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JALR   = 3'd4;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic [31:0] res;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// Retire-mask generator for the COMMIT_W oldest slots.
// In: per-slot valid/done/class, mem_busy. Out: retire mask.
module rob_commit_select
  import rob_multi_commit_pkg::*;
#(
  parameter int COMMIT_W = 2
) (
  input  logic [COMMIT_W-1:0]   slot_valid,
  input  logic [COMMIT_W-1:0]   slot_done,
  input  logic [COMMIT_W*3-1:0] slot_cls,
  input  logic                  mem_busy,
  output logic [COMMIT_W-1:0]   retire
);

  logic       go;
  logic       st_used;
  logic       ok;
  logic [2:0] c;

  always_comb begin
    retire  = '0;
    go      = 1'b1;
    st_used = 1'b0;
    ok      = 1'b0;
    c       = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      c  = slot_cls[k*3 +: 3];
      ok = go && slot_valid[k] && slot_done[k];
      if (c == CLS_STORE && (st_used || mem_busy))
        ok = 1'b0;
      retire[k] = ok;
      // control entries close the retire group
      go = ok && (c != CLS_BRANCH) && (c != CLS_JALR);
      if (ok && c == CLS_STORE)
        st_used = 1'b1;
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order issue, OoO writeback, up to COMMIT_W retires/cycle.
// Ports: issue (inst_*), writeback (wb_*), mem_busy; commit/branch/jalr/flush outs.
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int WB_PORTS    = 2,
  parameter int COMMIT_W    = 2,
  parameter int FULL_MARGIN = FULL_MARGIN_DEF
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         inst_req_in,
  input  logic [2:0]                   inst_class_in,
  input  logic [4:0]                   inst_rd_in,
  input  logic [31:0]                  inst_pc_in,
  input  logic [31:0]                  inst_imm_in,
  input  logic                         inst_pred_in,
  input  logic [WB_PORTS-1:0]          wb_valid_in,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_rob_id_in,
  input  logic [WB_PORTS*32-1:0]       wb_result_in,
  input  logic                         mem_busy_in,
  output logic [IDX_W-1:0]             head_out,
  output logic [IDX_W-1:0]             tail_out,
  output logic [IDX_W:0]               count_out,
  output logic                         full_out,
  output logic [COMMIT_W-1:0]          commit_valid_out,
  output logic [COMMIT_W*5-1:0]        commit_rd_out,
  output logic [COMMIT_W*32-1:0]       commit_val_out,
  output logic [COMMIT_W*IDX_W-1:0]    commit_rob_id_out,
  output logic                         store_commit_out,
  output logic                         br_valid_out,
  output logic                         br_taken_out,
  output logic                         br_correct_out,
  output logic                         jalr_valid_out,
  output logic [31:0]                  jalr_target_out,
  output logic                         flush_out,
  output logic [31:0]                  flush_pc_out
);

  localparam int CW = IDX_W + 1;

  rob_entry_t ent [DEPTH];

  logic [IDX_W-1:0] head, tail;
  logic [CW-1:0]    count;
  logic [IDX_W-1:0] s_id [COMMIT_W];

  logic [COMMIT_W-1:0]   s_valid, s_done, retire;
  logic [COMMIT_W*3-1:0] s_cls;

  always_comb begin
    s_valid = '0;
    s_done  = '0;
    s_cls   = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      s_id[k]         = head + IDX_W'(k);
      s_valid[k]      = ent[s_id[k]].valid;
      s_done[k]       = ent[s_id[k]].done;
      s_cls[k*3 +: 3] = ent[s_id[k]].cls;
    end
  end

  rob_commit_select #(
    .COMMIT_W (COMMIT_W)
  ) u_sel (
    .slot_valid (s_valid),
    .slot_done  (s_done),
    .slot_cls   (s_cls),
    .mem_busy   (mem_busy_in),
    .retire     (retire)
  );

  logic [CW-1:0]              n_ret, count_nx;
  logic                       issue, mispred;
  logic [COMMIT_W-1:0]        cv_nx;
  logic [COMMIT_W*5-1:0]      crd_nx;
  logic [COMMIT_W*32-1:0]     cval_nx;
  logic [COMMIT_W*IDX_W-1:0]  cid_nx;
  logic                       st_nx, brv_nx, brt_nx, brc_nx, jv_nx;
  logic [31:0]                jt_nx, fpc_nx;
  logic [2:0]                 k_cls;
  logic [4:0]                 k_rd;
  logic [31:0]                k_pc, k_imm, k_res;
  logic                       k_pred;

  always_comb begin
    n_ret   = '0;
    mispred = 1'b0;
    cv_nx   = '0;
    crd_nx  = '0;
    cval_nx = '0;
    cid_nx  = '0;
    st_nx   = 1'b0;
    brv_nx  = 1'b0;
    brt_nx  = 1'b0;
    brc_nx  = 1'b0;
    jv_nx   = 1'b0;
    jt_nx   = '0;
    fpc_nx  = '0;
    k_cls   = '0;
    k_rd    = '0;
    k_pc    = '0;
    k_imm   = '0;
    k_res   = '0;
    k_pred  = 1'b0;
    for (int k = 0; k < COMMIT_W; k++) begin
      k_cls  = ent[s_id[k]].cls;
      k_rd   = ent[s_id[k]].rd;
      k_pc   = ent[s_id[k]].pc;
      k_imm  = ent[s_id[k]].imm;
      k_res  = ent[s_id[k]].res;
      k_pred = ent[s_id[k]].pred;
      if (retire[k]) begin
        n_ret = n_ret + CW'(1);
        cv_nx[k] = 1'b1;
        cid_nx[k*IDX_W +: IDX_W] = s_id[k];
        unique case (1'b1)
          (k_cls == CLS_STORE): st_nx = 1'b1;
          (k_cls == CLS_BRANCH): begin
            brv_nx = 1'b1;
            brt_nx = k_res[0];
            brc_nx = (k_res[0] == k_pred);
            if (k_res[0] != k_pred) begin
              mispred = 1'b1;
              fpc_nx  = k_res[0] ? k_pc + k_imm : k_pc + 32'd4;
            end
          end
          (k_cls == CLS_JALR): begin
            jv_nx = 1'b1;
            jt_nx = k_res;
            crd_nx[k*5 +: 5]   = k_rd;
            cval_nx[k*32 +: 32] = k_pc + 32'd4;
          end
          default: begin
            crd_nx[k*5 +: 5]   = k_rd;
            cval_nx[k*32 +: 32] = k_res;
          end
        endcase
      end
    end
    issue    = inst_req_in && (count < CW'(DEPTH)) && !mispred;
    count_nx = mispred ? '0 : count + CW'(issue) - n_ret;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      full_out          <= 1'b0;
      commit_valid_out  <= '0;
      commit_rd_out     <= '0;
      commit_val_out    <= '0;
      commit_rob_id_out <= '0;
      store_commit_out  <= 1'b0;
      br_valid_out      <= 1'b0;
      br_taken_out      <= 1'b0;
      br_correct_out    <= 1'b0;
      jalr_valid_out    <= 1'b0;
      jalr_target_out   <= '0;
      flush_out         <= 1'b0;
      flush_pc_out      <= '0;
    end else if (rdy_in) begin
      for (int k = 0; k < COMMIT_W; k++)
        if (retire[k]) ent[s_id[k]].valid <= 1'b0;
      // descending so port 0 has the final say on a shared id
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_in[p] &&
            ent[wb_rob_id_in[p*IDX_W +: IDX_W]].valid &&
            !ent[wb_rob_id_in[p*IDX_W +: IDX_W]].done) begin
          ent[wb_rob_id_in[p*IDX_W +: IDX_W]].done <= 1'b1;
          ent[wb_rob_id_in[p*IDX_W +: IDX_W]].res  <=
            wb_result_in[p*32 +: 32];
        end
      end
      if (issue)
        ent[tail] <= '{valid: 1'b1, done: 1'b0,
                       cls: inst_class_in, rd: inst_rd_in,
                       pc: inst_pc_in, imm: inst_imm_in,
                       pred: inst_pred_in, res: 32'd0};
      head  <= head + n_ret[IDX_W-1:0];
      tail  <= tail + IDX_W'(issue);
      count <= count_nx;
      full_out <= (count_nx >= CW'(DEPTH - FULL_MARGIN));
      if (mispred) begin
        for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
        head <= '0;
        tail <= '0;
      end
      commit_valid_out  <= cv_nx;
      commit_rd_out     <= crd_nx;
      commit_val_out    <= cval_nx;
      commit_rob_id_out <= cid_nx;
      store_commit_out  <= st_nx;
      br_valid_out      <= brv_nx;
      br_taken_out      <= brt_nx;
      br_correct_out    <= brc_nx;
      jalr_valid_out    <= jv_nx;
      jalr_target_out   <= jt_nx;
      flush_out         <= mispred;
      flush_pc_out      <= fpc_nx;
    end
  end

  assign head_out  = head;
  assign tail_out  = tail;
  assign count_out = count;

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised reorder buffer for the out-of-order core: in-order issue from the instruction unit, out-of-order completion over WB_PORTS CDB writeback ports, in-order retirement of up to COMMIT_W entries per cycle.
- Sits between the instruction unit, the RS/LSB (writeback and CDB broadcast), the register file (commit) and the predictor (branch outcome).
- Adds over the single-commit generation: store commit gated by memory backpressure, and a single-edge flush with no dead cycle.

Parameters:
- DEPTH, 16, entries; power of two, at least 4.
- IDX_W, 4, log2(DEPTH).
- WB_PORTS, 2, number of writeback ports (RS, LSB, ...).
- COMMIT_W, 2, maximum retirements per cycle; 1 or 2.
- FULL_MARGIN, 2, full_out asserts when count >= DEPTH-FULL_MARGIN.

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  low freezes all state.
- inst_req_in  in  1  issue one entry at tail.
- inst_class_in  in  3  entry class: ALU/LOAD/STORE/BRANCH/JALR.
- inst_rd_in  in  5  destination register.
- inst_pc_in  in  32  instruction address.
- inst_imm_in  in  32  branch offset.
- inst_pred_in  in  1  predicted taken.
- wb_valid_in  in  WB_PORTS  per-port writeback strobe.
- wb_rob_id_in  in  WB_PORTS*IDX_W  packed entry ids.
- wb_result_in  in  WB_PORTS*32  packed results (branch: bit0 = taken; JALR: target).
- mem_busy_in  in  1  LSB cannot accept a store commit.
- head_out  out  IDX_W  oldest entry id.
- tail_out  out  IDX_W  id the next issue receives.
- count_out  out  IDX_W+1  occupancy.
- full_out  out  1  registered full flag.
- commit_valid_out  out  COMMIT_W  per-slot retire pulse.
- commit_rd_out  out  COMMIT_W*5  rd per slot; 0 for store/branch.
- commit_val_out  out  COMMIT_W*32  value per slot (JALR: pc+4).
- commit_rob_id_out  out  COMMIT_W*IDX_W  id per slot.
- store_commit_out  out  1  release oldest store in LSB.
- br_valid_out  out  1  branch retired this cycle.
- br_taken_out  out  1  resolved direction.
- br_correct_out  out  1  prediction matched.
- jalr_valid_out  out  1  JALR retired.
- jalr_target_out  out  32  JALR target.
- flush_out  out  1  pipeline flush pulse.
- flush_pc_out  out  32  redirect pc.

Behaviour:
- Reset: asynchronous on rst_n_in low. All outputs 0; head=tail=count=0; all entries invalid.
- rdy_in low: no state changes, outputs hold.
- Issue: when inst_req_in and count<DEPTH, write the tail entry (valid=1, done=0), tail+1 mod DEPTH. When count==DEPTH, inst_req_in is ignored. Tail wraps DEPTH-1 to 0.
- Writeback: for each port with valid set and the target entry valid and not done, latch the result and set done.
  - A write to an invalid entry is dropped (stale after a flush).
  - Two ports writing the same id in one cycle: the lowest port index wins.
  - An entry written back at edge t can retire at edge t+1 at the earliest.
- Commit candidates: slot k = entry head+k, for k < COMMIT_W. Slot k retires only if all of the following hold:
  - it is valid and done;
  - every lower slot retires;
  - no lower slot is BRANCH or JALR, so a control entry is always the last retirement of its cycle;
  - at most one STORE retires per cycle, and only when mem_busy_in is 0. A blocked store blocks all younger slots.
- Commit outputs are registered, so every *_out pulse is one cycle wide in the cycle after the retiring edge.
  - ALU/LOAD: rd and result.
  - STORE: store_commit_out=1, rd=0.
  - BRANCH: br_valid/br_taken/br_correct; rd=0.
  - JALR: rd, value pc+4, jalr_valid_out=1, target = result.
- Mispredict (BRANCH with taken != pred): at the retiring edge, invalidate all entries and set head=tail=count=0. flush_out=1 for one cycle with flush_pc = taken ? pc+imm : pc+4. Older same-cycle retirements are still reported. inst_req_in in the flush edge is ignored.
- Count update: count_next = count + issued - retired. full_out is registered from count_next >= DEPTH-FULL_MARGIN.
- Simultaneous issue and retire when full: legal; count stays unchanged.

Decomposition:
- Shared package constants: class encodings CLS_ALU=0, CLS_LOAD=1, CLS_STORE=2, CLS_BRANCH=3, CLS_JALR=4; DEPTH/IDX_W defaults; FULL_MARGIN.
- One sub-module, rob_commit_select: combinational retire-mask generator from per-slot valid/done/class and mem_busy_in. It is unit-testable on its own.

Test Plan:
- Issue 3 ALU (rd 5,6,7); write back ids 2,0,1 with 0x11,0x22,0x33 over ports 0/1 → commits of rd5=0x22 and rd6=0x33 in one cycle, then rd7=0x11 one cycle later.
- Two STOREs done, mem_busy_in=1 for 3 cycles → no commit; after release, store_commit_out pulses on 2 consecutive cycles (one per cycle).
- BRANCH pc=0x100, imm=0x40, pred=0, result taken, 4 younger entries → flush_out=1 with flush_pc=0x140; count_out=0; a late writeback to a younger id is ignored.
- Fill to count 14 with DEPTH=16 → full_out=1; issue up to 16; a 17th inst_req is ignored; tail wraps to 0 after retirements.
- JALR pc=0x200, rd=1, result 0x300, in slot 0 followed by an ALU that is done → only the JALR retires (val 0x204, jalr_target 0x300); the ALU retires the next cycle.
- rst_n_in pulsed low mid-operation, asynchronous to clk_in → all outputs 0 immediately and the buffer is empty.
